// File: rtl/ramb16_s36_arb_if.sv
// Client request/response bundle for one port of the ramb16_s36_arb arbiter.
// gnt is the accept for a held req; rvalid/rdata return two cycles after the grant.
interface ramb16_s36_arb_if;
  logic        req;
  logic        we;
  logic [8:0]  addr;
  logic [31:0] di;
  logic [3:0]  dip;
  logic        gnt;
  logic        rvalid;
  logic [35:0] rdata;

  modport master (
    output req, we, addr, di, dip,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, di, dip,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ramb16_s36_arb.sv
// Two-port round-robin arbiter in front of one 512x36 RAM port, with power-up/runtime clear.
// Grant is same-cycle, rvalid two cycles later; requests stall (no gnt) during clear or when losing.
module ramb16_s36_arb #(
  parameter int          CLEAR_ON_RESET = 1,
  parameter logic [35:0] CLEAR_VAL      = 36'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  ramb16_s36_arb_if.slave   a,
  ramb16_s36_arb_if.slave   b,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [8:0]        ram_addr,
  output logic [31:0]       ram_di,
  output logic [3:0]        ram_dip,
  input  logic [31:0]       ram_do,
  input  logic [3:0]        ram_dop
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;
  localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;

  logic [0:0] state;
  logic [8:0] cnt;
  logic       prio_b;
  logic       serve_ok;
  logic       gnt_a;
  logic       gnt_b;
  logic       rv1_a;
  logic       rv1_b;
  logic       rvalid_a;
  logic       rvalid_b;

  // A pending clr takes the cycle, so no grant may be issued alongside it.
  assign serve_ok = (state == SERVE) && !clr && !rst;
  assign gnt_a    = serve_ok && a.req && (!b.req || !prio_b);
  assign gnt_b    = serve_ok && b.req && (!a.req || prio_b);

  assign busy     = (state == CLEAR);
  assign a.gnt    = gnt_a;
  assign b.gnt    = gnt_b;
  assign a.rvalid = rvalid_a;
  assign b.rvalid = rvalid_b;
  assign a.rdata  = {ram_dop, ram_do};
  assign b.rdata  = {ram_dop, ram_do};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      cnt      <= 9'd0;
      prio_b   <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= 9'd0;
      ram_di   <= 32'd0;
      ram_dip  <= 4'd0;
      rv1_a    <= 1'b0;
      rv1_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      rv1_a    <= gnt_a;
      rv1_b    <= gnt_b;
      rvalid_a <= rv1_a;
      rvalid_b <= rv1_b;
      case (state)
        CLEAR: begin
          ram_en            <= 1'b1;
          ram_we            <= 1'b1;
          ram_addr          <= cnt;
          {ram_dip, ram_di} <= CLEAR_VAL;
          // Leave on the edge that issues the last word; the counter never wraps.
          if (cnt == 9'd511) begin
            state <= SERVE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= 9'd0;
          end else if (gnt_a) begin
            ram_en   <= 1'b1;
            ram_we   <= a.we;
            ram_addr <= a.addr;
            ram_di   <= a.di;
            ram_dip  <= a.dip;
            prio_b   <= 1'b1;
          end else if (gnt_b) begin
            ram_en   <= 1'b1;
            ram_we   <= b.we;
            ram_addr <= b.addr;
            ram_di   <= b.di;
            ram_dip  <= b.dip;
            prio_b   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
